// File: rtl/crc8_serial_if.sv
// Serial message/CRC signal bundle for the bit-serial CRC-8 generator.
// The master drives message bits; the slave returns the serial CRC.
interface crc8_serial_if;
    logic DATA;
    logic ACTIVE;
    logic CRC;
    logic Valid;

    modport master (output DATA, output ACTIVE, input CRC, input Valid);
    modport slave  (input DATA, input ACTIVE, output CRC, output Valid);
endinterface

// File: rtl/crc8_serial.sv
// Bit-serial CRC generator: absorbs one message bit per clock while ACTIVE is high,
// then shifts the LFSR contents out LSB-first with Valid high for WIDTH cycles.
module crc8_serial #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 8'hD8,
    parameter logic [WIDTH-1:0] TAPS  = 8'b0100_0100
) (
    input  logic         CLK,
    input  logic         RST,
    crc8_serial_if.slave bus
);

    localparam int unsigned    CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_DONE = CW'(WIDTH);

    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             armed_q, armed_d;
    logic             crc_q, crc_d;
    logic             valid_q, valid_d;
    logic             fb;

    always_comb begin
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        crc_d   = crc_q;
        valid_d = 1'b0;
        fb      = bus.DATA ^ lfsr_q[0];

        if (bus.ACTIVE) begin
            // Top bit takes only the feedback; lower bits get it where a tap is set.
            lfsr_d  = {fb, lfsr_q[WIDTH-1:1]} ^ ({WIDTH{fb}} & {1'b0, TAPS[WIDTH-2:0]});
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (armed_q && (cnt_q != CNT_DONE)) begin
            crc_d   = lfsr_q[0];
            lfsr_d  = {1'b0, lfsr_q[WIDTH-1:1]};
            valid_d = 1'b1;
            cnt_d   = cnt_q + 1'b1;
        end else if (cnt_q == CNT_DONE) begin
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            crc_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            crc_q   <= crc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.CRC   = crc_q;
    assign bus.Valid = valid_q;

endmodule

// File: tb/tb_crc8_serial.sv
// Self-checking bench for crc8_serial: fixed vectors, random frames against a
// reference CRC model, shift-out abort and asynchronous reset sequences.
module tb_crc8_serial;

    localparam logic [7:0] SEED_C = 8'hD8;
    localparam logic [7:0] TAPS_C = 8'h44;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    crc8_serial_if bus ();

    crc8_serial dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] msg;
        int         len;
        logic [7:0] expCrc;
    } vec_t;

    vec_t vecs [4];

    // One message bit folds into the register as a division step by the generator polynomial.
    function automatic logic [7:0] modelAbsorb(input logic [7:0] s, input logic b);
        logic fbit;
        fbit = b ^ s[0];
        return (s >> 1) ^ (fbit ? (8'h80 | TAPS_C) : 8'h00);
    endfunction

    function automatic logic [7:0] modelCrc(input logic [63:0] bits, input int len);
        logic [7:0] s;
        s = SEED_C;
        for (int i = 0; i < len; i++) s = modelAbsorb(s, bits[i]);
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] bits, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge CLK);
            bus.ACTIVE = 1'b1;
            bus.DATA   = bits[i];
        end
        @(negedge CLK);
        bus.ACTIVE = 1'b0;
        bus.DATA   = 1'b0;
    endtask

    task automatic collectCrc(input int nbits, output logic [7:0] got, output int vcount);
        got    = '0;
        vcount = 0;
        for (int m = 0; m < nbits; m++) begin
            @(negedge CLK);
            if (bus.Valid === 1'b1) vcount++;
            got[m] = bus.CRC;
        end
    endtask

    task automatic doReset();
        @(negedge CLK);
        RST        = 1'b0;
        bus.ACTIVE = 1'b0;
        bus.DATA   = 1'b0;
        @(negedge CLK);
        checkOutput("valid during reset", 32'(bus.Valid), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic runFrame(input string name, input logic [63:0] bits, input int len,
                            input logic [7:0] exp);
        logic [7:0] got;
        int         vcount;
        applyStimulus(bits, len);
        collectCrc(8, got, vcount);
        checkOutput({name, " crc"}, 32'(got), 32'(exp));
        checkOutput({name, " valid cycles"}, 32'(vcount), 32'd8);
        @(negedge CLK);
        checkOutput({name, " valid falls"}, 32'(bus.Valid), 32'd0);
    endtask

    initial begin
        logic [63:0] rbits;
        logic [63:0] extra;
        logic [7:0]  got;
        logic [7:0]  s;
        int          vcount;
        int          rlen;

        vecs[0] = '{msg: 8'h00, len: 8, expCrc: 8'h14};
        vecs[1] = '{msg: 8'h01, len: 8, expCrc: 8'hBF};
        vecs[2] = '{msg: 8'h00, len: 1, expCrc: 8'h6C};
        vecs[3] = '{msg: 8'h01, len: 1, expCrc: 8'hA8};

        bus.DATA   = 1'b0;
        bus.ACTIVE = 1'b0;

        // Power-on reset and idle behaviour
        #2 RST = 1'b0;
        #1;
        checkOutput("reset lfsr", 32'(dut.lfsr_q), 32'(SEED_C));
        checkOutput("reset valid", 32'(bus.Valid), 32'd0);
        checkOutput("reset crc", 32'(bus.CRC), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        collectCrc(6, got, vcount);
        checkOutput("idle valid cycles", 32'(vcount), 32'd0);
        checkOutput("idle lfsr", 32'(dut.lfsr_q), 32'(SEED_C));

        // Fixed vectors
        for (int v = 0; v < 4; v++) begin
            doReset();
            runFrame($sformatf("vec%0d", v), 64'(vecs[v].msg), vecs[v].len, vecs[v].expCrc);
        end

        // Random back-to-back frames
        for (int f = 0; f < 10; f++) begin
            rbits = {$urandom, $urandom};
            rlen  = $urandom_range(1, 40);
            doReset();
            runFrame($sformatf("rand%0d", f), rbits, rlen, modelCrc(rbits, rlen));
        end

        // ACTIVE re-asserted after three CRC bits
        doReset();
        rbits = 64'h5A;
        extra = 64'(4'b1011);
        applyStimulus(rbits, 8);
        collectCrc(3, got, vcount);
        s = modelCrc(rbits, 8);
        checkOutput("abort first bits", 32'(got[2:0]), 32'(s[2:0]));
        checkOutput("abort first valid", 32'(vcount), 32'd3);
        bus.ACTIVE = 1'b1;
        bus.DATA   = extra[0];
        @(negedge CLK);
        checkOutput("abort valid drop", 32'(bus.Valid), 32'd0);
        checkOutput("abort cnt clear", 32'(dut.cnt_q), 32'd0);
        s = modelAbsorb(s >> 3, extra[0]);
        for (int i = 1; i < 4; i++) begin
            bus.DATA = extra[i];
            s = modelAbsorb(s, extra[i]);
            @(negedge CLK);
        end
        bus.ACTIVE = 1'b0;
        bus.DATA   = 1'b0;
        collectCrc(8, got, vcount);
        checkOutput("abort resumed crc", 32'(got), 32'(s));
        checkOutput("abort resumed valid", 32'(vcount), 32'd8);
        @(negedge CLK);
        checkOutput("abort valid falls", 32'(bus.Valid), 32'd0);

        // Asynchronous reset in the middle of absorption
        doReset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus.ACTIVE = 1'b1;
            bus.DATA   = 1'b1;
        end
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        checkOutput("absorb reset lfsr", 32'(dut.lfsr_q), 32'(SEED_C));
        checkOutput("absorb reset valid", 32'(bus.Valid), 32'd0);
        @(negedge CLK);
        bus.ACTIVE = 1'b0;
        RST        = 1'b1;

        // Asynchronous reset in the middle of shift-out (CRC 0x14: third bit is 1)
        doReset();
        applyStimulus(64'h00, 8);
        collectCrc(2, got, vcount);
        @(posedge CLK);
        #2;
        checkOutput("pre-reset crc bit", 32'(bus.CRC), 32'd1);
        checkOutput("pre-reset valid", 32'(bus.Valid), 32'd1);
        RST = 1'b0;
        #1;
        checkOutput("shift reset valid", 32'(bus.Valid), 32'd0);
        checkOutput("shift reset crc", 32'(bus.CRC), 32'd0);
        checkOutput("shift reset lfsr", 32'(dut.lfsr_q), 32'(SEED_C));
        @(negedge CLK);
        RST = 1'b1;
        collectCrc(10, got, vcount);
        checkOutput("post-reset quiet", 32'(vcount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_serial.md
# crc8_serial

Bit-serial CRC-8 generator built on an internal 8-bit LFSR. It absorbs one message bit per clock while `ACTIVE` is high. When `ACTIVE` falls, it shifts the 8-bit CRC out LSB-first on `CRC`, with `Valid` high for exactly 8 cycles. It sits at the tail of a serial transmit path and appends the checksum after each frame.

## Interface
- `WIDTH`, default 8: LFSR/CRC width and number of output bits.
- `SEED`, default 8'hD8: LFSR value loaded on reset.
- `TAPS`, default 8'b0100_0100: feedback tap mask; bit n set means LFSR[n] takes LFSR[n+1] XOR feedback.
- `CLK`, input, 1: single clock; all state updates on the rising edge.
- `RST`, input, 1: reset, asynchronous and active-low.
- `DATA`, input, 1: serial message bit, sampled on the rising edge while `ACTIVE`=1.
- `ACTIVE`, input, 1: high for the message duration, one bit per cycle.
- `CRC`, output, 1: serial CRC bit, registered.
- `Valid`, output, 1: high while `CRC` carries a valid CRC bit, registered.

## Operation
- **State:** `LFSR[7:0]`, a 4-bit output counter `cnt`, and an `armed` flag.
- **Reset (`RST`=0, immediate):** `LFSR`=`SEED`, `CRC`=0, `Valid`=0, `cnt`=0, `armed`=0.
- **Absorb (`ACTIVE`=1), each rising edge:**
  - `fb` = `DATA` XOR `LFSR[0]`.
  - `LFSR[7]` <= `fb`.
  - For n=6..0: `LFSR[n]` <= `LFSR[n+1]` XOR (`TAPS[n]` AND `fb`).
  - `Valid`<=0, `CRC` holds, `cnt`<=0, `armed`<=1.
- **Shift-out (`ACTIVE`=0, `armed`=1, `cnt`<8), each rising edge:**
  - `CRC` <= `LFSR[0]`.
  - `LFSR` <= `LFSR` >> 1, with 0 filled into bit 7.
  - `Valid`<=1, `cnt`<=`cnt`+1.
- **Done/idle (`ACTIVE`=0, and `armed`=0 or `cnt`=8):**
  - `Valid`<=0, `CRC` holds its last value, `LFSR` holds.
  - When `cnt` reaches 8, `armed`<=0.
- **Bit order:** message bits are consumed in arrival order. The CRC leaves LSB (`LFSR[0]`) first. The receiver reassembles it as `crc[m]` = m-th bit out.
- **Seeding:** the LFSR is reseeded only by reset. Frames must be separated by a reset to start from `SEED`.
- **Re-assertion:** if `ACTIVE` re-asserts during shift-out, shift-out aborts immediately. Absorption resumes from the current (partially shifted) `LFSR`, and `cnt` clears.
- **Idle after reset:** with `ACTIVE` never asserted, nothing is shifted out; `Valid` stays 0.

## Timing
- **Absorb:** one message bit per cycle, no stall, no backpressure.
- **CRC latency:** at the first rising edge where `ACTIVE`=0 after absorption, `Valid` goes 1 and `CRC`=bit0. Bits 1..7 follow on the next 7 edges. `Valid` falls on the 9th edge.
- **Sampling window:** `CRC` and `Valid` change only just after rising edges and are stable across the following falling edge, which is the sampling point.
- **Reset mid-operation:** reset during absorb or shift-out aborts at once. Outputs go to 0 and the `LFSR` goes to `SEED` without waiting for a clock edge.
- **Message length:** unconstrained, 1 to unbounded bits; the CRC covers every cycle with `ACTIVE`=1.

## Test plan
- **Reset values:** assert `RST`=0 mid-stream. Expect `CRC`=0 and `Valid`=0 immediately. After release, `LFSR`=8'hD8 (hierarchical check) and `Valid` stays 0 with `ACTIVE`=0.
- **Message 8'h00:** after reset, drive bits 0..7 LSB-first (8 cycles `ACTIVE`=1), then `ACTIVE`=0. Expect `Valid` high for exactly 8 cycles; serial bits 0,0,1,0,1,0,0,0, reassembled value 8'h14.
- **Message 8'h01:** after reset, drive bits 1,0,0,0,0,0,0,0. Expect the reassembled CRC to be 8'hBF.
- **Back-to-back frames:** run ten frames, each followed by a 2-cycle reset. Expect each CRC to match a software model (`SEED` D8, `TAPS` 0x44, same update rule) and no `Valid` glitch between frames.
- **Abort by `ACTIVE` during shift-out:** re-raise `ACTIVE` after 3 CRC bits. Expect `Valid`=0 on the next edge and `cnt` cleared. After `ACTIVE` drops, a fresh 8-cycle `Valid` burst appears.
- **Async reset during shift-out:** drop `RST` mid-burst, asynchronous to `CLK`. Expect `Valid`=0 and `CRC`=0 without waiting for an edge, and no further output until a new frame.
